// File: rtl/alu_slice_bist.sv
// Self-test engine for the 1-bit ALU slice: walks a ROM of stimulus/expected vectors,
// counts mismatches and flags failing op groups. Optional first-fail logging: ALU_BIST_LOG_EN.
`default_nettype none

module alu_slice_bist #(
    parameter int NUM_VEC = 60,
    parameter int VEC_W   = 12,
    parameter int ADDR_W  = 6,
    parameter int ERR_W   = 8,
    parameter int GRP_SZ  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [VEC_W-1:0]  vec_data,
    output logic [2:0]        ALUcontrol,
    output logic              SrcA,
    output logic              SrcB,
    output logic              cin,
    output logic              addSubSignal,
    output logic              less,
    input  logic              set,
    input  logic              ALUresult,
    input  logic              cout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [7:0]        grp_fail,
    output logic [ADDR_W-1:0] first_fail,
    output logic [2:0]        first_resp
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_APPLY, S_CHECK, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [2:0]        exp_p1;
    logic [2:0]        resp;
    logic [2:0]        grp_sel;
    logic              last_vec;
    logic              launch;
    logic              mismatch;
    logic              unused_rom_bits;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign resp            = {set, ALUresult, cout};
    assign last_vec        = (idx == ADDR_W'(NUM_VEC - 1));
    assign launch          = start && (state == S_IDLE || state == S_DONE);
    // Case inequality so an X/Z response from the slice is always a failure.
    assign mismatch        = (state == S_CHECK) && (resp !== exp_p1);
    assign grp_sel         = 3'(idx / ADDR_W'(GRP_SZ));
    assign unused_rom_bits = ^vec_data[VEC_W-1:11];

    assign vec_addr = idx;
    assign busy     = (state == S_FETCH) || (state == S_APPLY) || (state == S_CHECK);
    assign done     = (state == S_DONE);
    assign pass     = done && (err_count == '0);

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_APPLY;
            S_APPLY: state_nxt = S_CHECK;
            S_CHECK: state_nxt = last_vec ? S_DONE : S_FETCH;
            S_DONE:  if (start) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    // APPLY -> CHECK: ROM word registered onto the slice drives plus the expected response
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx          <= '0;
            ALUcontrol   <= '0;
            SrcA         <= 1'b0;
            SrcB         <= 1'b0;
            cin          <= 1'b0;
            addSubSignal <= 1'b0;
            less         <= 1'b0;
            exp_p1       <= '0;
            err_count    <= '0;
            grp_fail     <= '0;
        end else begin
            if (launch) begin
                idx       <= '0;
                err_count <= '0;
                grp_fail  <= '0;
            end else if (state == S_CHECK && !last_vec) begin
                idx <= idx + 1'b1;
            end
            if (state == S_APPLY) begin
                ALUcontrol   <= vec_data[10:8];
                SrcA         <= vec_data[7];
                SrcB         <= vec_data[6];
                cin          <= vec_data[5];
                addSubSignal <= vec_data[4];
                less         <= vec_data[3];
                exp_p1       <= vec_data[2:0];
            end
            if (mismatch) begin
                err_count         <= sat_inc(err_count);
                grp_fail[grp_sel] <= 1'b1;
            end
        end
    end

`ifdef ALU_BIST_LOG_EN
    logic logged;

    // CHECK: first mismatch of the run is latched, later ones ignored until the next start
    always_ff @(posedge clk) begin
        if (!rst) begin
            first_fail <= '0;
            first_resp <= '0;
            logged     <= 1'b0;
        end else if (launch) begin
            first_fail <= '0;
            first_resp <= '0;
            logged     <= 1'b0;
        end else if (mismatch && !logged) begin
            first_fail <= idx;
            first_resp <= resp;
            logged     <= 1'b1;
        end
    end
`else
    assign first_fail = '0;
    assign first_resp = '0;
`endif

endmodule

`default_nettype wire
